// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit barrel shifter between two requesters.
// Optional grant counters GntCnt0/GntCnt1 are built when SHIFT_ARB_CNT_EN is defined.
module shift_arbiter #(
   parameter int N = 16,
   parameter int C = 4,
   parameter int O = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   ReqValid,
   output logic [1:0]   ReqReady,
   input  logic [N-1:0] In0,
   input  logic [N-1:0] In1,
   input  logic [C-1:0] Cnt0,
   input  logic [C-1:0] Cnt1,
   input  logic [O-1:0] Op0,
   input  logic [O-1:0] Op1,
   output logic         ResValid,
   input  logic         ResReady,
   output logic [N-1:0] Out,
   output logic         ResId
`ifdef SHIFT_ARB_CNT_EN
   ,
   output logic [15:0]  GntCnt0,
   output logic [15:0]  GntCnt1
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   out_q, out_d;
   logic           id_q, id_d;
   logic           last_q, last_d;

   logic           free;
   logic           gnt_any;
   logic           gnt_idx;
   logic [N-1:0]   sh_in;
   logic [C-1:0]   sh_cnt;
   logic [O-1:0]   sh_op;
   logic [N-1:0]   sh_res;
   logic [2*N-1:0] rol_wide;

   // Arbitration: a tie goes to the requester not served last.
   always_comb begin
      free    = (state_q == EMPTY) | ResReady;
      gnt_any = 1'b0;
      gnt_idx = 1'b0;
      if (rst_n && free) begin
         case (ReqValid)
            2'b01:   begin gnt_any = 1'b1; gnt_idx = 1'b0;    end
            2'b10:   begin gnt_any = 1'b1; gnt_idx = 1'b1;    end
            2'b11:   begin gnt_any = 1'b1; gnt_idx = ~last_q; end
            default: begin gnt_any = 1'b0; gnt_idx = 1'b0;    end
         endcase
      end
      ReqReady = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
   end

   always_comb begin
      sh_in  = gnt_idx ? In1  : In0;
      sh_cnt = gnt_idx ? Cnt1 : Cnt0;
      sh_op  = gnt_idx ? Op1  : Op0;
   end

   // Rotate-left taken as the upper half of the doubled operand shifted left.
   always_comb begin
      rol_wide = {sh_in, sh_in} << sh_cnt;
      sh_res   = sh_in;
      case (sh_op)
         2'b00: sh_res = rol_wide[2*N-1:N];
         2'b01: sh_res = sh_in << sh_cnt;
         2'b10: sh_res = $signed(sh_in) >>> sh_cnt;
         2'b11: sh_res = sh_in >> sh_cnt;
      endcase
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      id_d    = id_q;
      last_d  = last_q;
      case (state_q)
         EMPTY:   if (gnt_any) state_d = FULL;
         FULL:    if (ResReady && !gnt_any) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (gnt_any) begin
         out_d  = sh_res;
         id_d   = gnt_idx;
         last_d = gnt_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         out_q   <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   assign ResValid = (state_q == FULL);
   assign Out      = out_q;
   assign ResId    = id_q;

`ifdef SHIFT_ARB_CNT_EN
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (gnt_any && !gnt_idx && (cnt0_q != '1)) cnt0_d = cnt0_q + 16'd1;
      if (gnt_any &&  gnt_idx && (cnt1_q != '1)) cnt1_d = cnt1_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign GntCnt0 = cnt0_q;
   assign GntCnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed sequences, a vector table and random traffic
// checked against a bit-serial reference model (SHIFT_ARB_CNT_EN adds a counter saturation test).
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  ReqValid;
   logic [1:0]  ReqReady;
   logic [15:0] In0, In1;
   logic [3:0]  Cnt0, Cnt1;
   logic [1:0]  Op0, Op1;
   logic        ResValid;
   logic        ResReady;
   logic [15:0] Out;
   logic        ResId;
`ifdef SHIFT_ARB_CNT_EN
   logic [15:0] GntCnt0, GntCnt1;
`endif

   shift_arbiter #(.N(16), .C(4), .O(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ReqValid(ReqValid), .ReqReady(ReqReady),
      .In0(In0), .In1(In1), .Cnt0(Cnt0), .Cnt1(Cnt1), .Op0(Op0), .Op1(Op1),
      .ResValid(ResValid), .ResReady(ResReady), .Out(Out), .ResId(ResId)
`ifdef SHIFT_ARB_CNT_EN
      , .GntCnt0(GntCnt0), .GntCnt1(GntCnt1)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_valid = 1'b0;
   logic [15:0] m_out   = '0;
   bit          m_id    = 1'b0;
   bit          m_last  = 1'b1;
   int unsigned m_c0    = 0;
   int unsigned m_c1    = 0;
   logic [1:0]  m_er;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One bit position per iteration, straight from the op definitions.
   function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [3:0] c,
                                             input logic [1:0] op);
      logic [15:0] v;
      v = x;
      for (int k = 0; k < int'(c); k++) begin
         case (op)
            2'b00: v = {v[14:0], v[15]};
            2'b01: v = {v[14:0], 1'b0};
            2'b10: v = {v[15], v[15:1]};
            default: v = {1'b0, v[15:1]};
         endcase
      end
      return v;
   endfunction

   function automatic logic [1:0] exp_rdy();
      if (!rst_n) return 2'b00;
      if (m_valid && !ResReady) return 2'b00;
      case (ReqValid)
         2'b01:   return 2'b01;
         2'b10:   return 2'b10;
         2'b11:   return m_last ? 2'b01 : 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   // Inputs already driven; check ReqReady, clock once, advance model, check outputs.
   task automatic step();
      bit          n_valid, n_id, n_last;
      logic [15:0] n_out;
      int unsigned n_c0, n_c1;
      #1;
      m_er = exp_rdy();
      chk("ReqReady", {30'd0, ReqReady}, {30'd0, m_er});
      n_valid = m_valid; n_out = m_out; n_id = m_id; n_last = m_last; n_c0 = m_c0; n_c1 = m_c1;
      if (!rst_n) begin
         n_valid = 0; n_out = '0; n_id = 0; n_last = 1; n_c0 = 0; n_c1 = 0;
      end else if (m_er != 2'b00) begin
         n_id    = m_er[1];
         n_last  = m_er[1];
         n_valid = 1;
         n_out   = m_er[1] ? ref_shift(In1, Cnt1, Op1) : ref_shift(In0, Cnt0, Op0);
         if (m_er[1]) begin if (n_c1 < 32'hFFFF) n_c1++; end
         else         begin if (n_c0 < 32'hFFFF) n_c0++; end
      end else if (ResReady) begin
         n_valid = 0;
      end
      @(posedge clk);
      m_valid = n_valid; m_out = n_out; m_id = n_id; m_last = n_last; m_c0 = n_c0; m_c1 = n_c1;
      #1;
      chk("ResValid", {31'd0, ResValid}, {31'd0, m_valid});
      chk("Out", {16'd0, Out}, {16'd0, m_out});
      chk("ResId", {31'd0, ResId}, {31'd0, m_id});
`ifdef SHIFT_ARB_CNT_EN
      chk("GntCnt0", {16'd0, GntCnt0}, m_c0);
      chk("GntCnt1", {16'd0, GntCnt1}, m_c1);
`endif
   endtask

   typedef struct {
      logic [1:0]  rv;
      logic [15:0] in0;  logic [3:0] c0; logic [1:0] op0;
      logic [15:0] in1;  logic [3:0] c1; logic [1:0] op1;
      logic [1:0]  rdy;
      logic        vld;
      logic [15:0] out;
      logic        id;
   } vec_t;

   vec_t vecs[$];

   initial begin
      bit keep0, keep1;

      vecs.push_back('{2'b01, 16'h8001, 4'd1,  2'b00, 16'h0000, 4'd0, 2'b00, 2'b01, 1'b1, 16'h0003, 1'b0});
      vecs.push_back('{2'b10, 16'h0000, 4'd0,  2'b00, 16'h8000, 4'd4, 2'b10, 2'b10, 1'b1, 16'hF800, 1'b1});
      vecs.push_back('{2'b10, 16'h0000, 4'd0,  2'b00, 16'h8000, 4'd4, 2'b11, 2'b10, 1'b1, 16'h0800, 1'b1});
      vecs.push_back('{2'b01, 16'h0001, 4'd15, 2'b01, 16'h0000, 4'd0, 2'b00, 2'b01, 1'b1, 16'h8000, 1'b0});
      vecs.push_back('{2'b01, 16'hA5A5, 4'd0,  2'b00, 16'h0000, 4'd0, 2'b00, 2'b01, 1'b1, 16'hA5A5, 1'b0});
      vecs.push_back('{2'b10, 16'h0000, 4'd0,  2'b00, 16'hA5A5, 4'd0, 2'b01, 2'b10, 1'b1, 16'hA5A5, 1'b1});
      vecs.push_back('{2'b01, 16'hA5A5, 4'd0,  2'b10, 16'h0000, 4'd0, 2'b00, 2'b01, 1'b1, 16'hA5A5, 1'b0});
      vecs.push_back('{2'b10, 16'h0000, 4'd0,  2'b00, 16'hA5A5, 4'd0, 2'b11, 2'b10, 1'b1, 16'hA5A5, 1'b1});
      vecs.push_back('{2'b00, 16'h1234, 4'd3,  2'b01, 16'h4321, 4'd2, 2'b11, 2'b00, 1'b0, 16'hA5A5, 1'b1});

      // Reset with both requesting
      rst_n = 1'b0; ReqValid = 2'b11; ResReady = 1'b0;
      In0 = 16'h8001; Cnt0 = 4'd1; Op0 = 2'b00;
      In1 = 16'h8000; Cnt1 = 4'd4; Op1 = 2'b10;
      #1 chk("rst_ReqReady", {30'd0, ReqReady}, 32'd0);
      step();
      chk("rst_ResValid", {31'd0, ResValid}, 32'd0);
      chk("rst_Out", {16'd0, Out}, 32'd0);
      chk("rst_ResId", {31'd0, ResId}, 32'd0);

      // Round robin, back-to-back results, req0 first after reset
      rst_n = 1'b1; ResReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("rr_ReqReady", {30'd0, ReqReady}, (i % 2) ? 32'd2 : 32'd1);
         step();
         chk("rr_ResId", {31'd0, ResId}, i % 2);
         chk("rr_ResValid", {31'd0, ResValid}, 32'd1);
         chk("rr_Out", {16'd0, Out}, (i % 2) ? 32'hF800 : 32'h0003);
      end

      // Backpressure: nothing granted, result held
      ResReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ReqReady", {30'd0, ReqReady}, 32'd0);
         step();
         chk("bp_Out", {16'd0, Out}, 32'hF800);
         chk("bp_ResId", {31'd0, ResId}, 32'd1);
         chk("bp_ResValid", {31'd0, ResValid}, 32'd1);
      end
      ResReady = 1'b1;
      #1 chk("rel_ReqReady", {30'd0, ReqReady}, 32'd1);
      step();
      chk("rel_Out", {16'd0, Out}, 32'h0003);

      // Vector table
      foreach (vecs[i]) begin
         ReqValid = vecs[i].rv; ResReady = 1'b1;
         In0 = vecs[i].in0; Cnt0 = vecs[i].c0; Op0 = vecs[i].op0;
         In1 = vecs[i].in1; Cnt1 = vecs[i].c1; Op1 = vecs[i].op1;
         #1 chk($sformatf("vec%0d_ReqReady", i), {30'd0, ReqReady}, {30'd0, vecs[i].rdy});
         step();
         chk($sformatf("vec%0d_ResValid", i), {31'd0, ResValid}, {31'd0, vecs[i].vld});
         chk($sformatf("vec%0d_Out", i), {16'd0, Out}, {16'd0, vecs[i].out});
         chk($sformatf("vec%0d_ResId", i), {31'd0, ResId}, {31'd0, vecs[i].id});
      end

      // Reset while a result is pending
      ReqValid = 2'b01; ResReady = 1'b0; In0 = 16'h00F0; Cnt0 = 4'd2; Op0 = 2'b01;
      step();
      chk("pend_ResValid", {31'd0, ResValid}, 32'd1);
      rst_n = 1'b0;
      step();
      chk("rstpend_ResValid", {31'd0, ResValid}, 32'd0);
      chk("rstpend_Out", {16'd0, Out}, 32'd0);
      rst_n = 1'b1;

      // Random traffic against the model; requests hold their data until accepted
      keep0 = 0; keep1 = 0;
      for (int i = 0; i < 400; i++) begin
         rst_n    = ($urandom_range(0, 59) != 0);
         ResReady = ($urandom_range(0, 3) != 0);
         if (!keep0) begin
            ReqValid[0] = $urandom_range(0, 1);
            In0 = 16'($urandom); Cnt0 = 4'($urandom); Op0 = 2'($urandom);
         end
         if (!keep1) begin
            ReqValid[1] = $urandom_range(0, 1);
            In1 = 16'($urandom); Cnt1 = 4'($urandom); Op1 = 2'($urandom);
         end
         step();
         keep0 = ReqValid[0] && !m_er[0] && rst_n;
         keep1 = ReqValid[1] && !m_er[1] && rst_n;
      end

`ifdef SHIFT_ARB_CNT_EN
      rst_n = 1'b0; ReqValid = 2'b00; ResReady = 1'b1;
      step();
      rst_n = 1'b1; ReqValid = 2'b01;
      In0 = 16'h0001; Cnt0 = 4'd1; Op0 = 2'b01;
      for (int i = 0; i < 32'h10005; i++) @(posedge clk);
      #1;
      chk("sat_GntCnt0", {16'd0, GntCnt0}, 32'h0000FFFF);
      chk("sat_GntCnt1", {16'd0, GntCnt1}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
